enable_scheduler: RTL and testbench
===================================

# enable_scheduler

Upstream feeder for the dual-bank enable-gated capture register. It accepts 5-bit words tagged with a destination bank over a valid/ready handshake and buffers them in a small FIFO. It issues each word as a registered data bus plus single-cycle EN1/EN2 strobes. A programmable quiet gap is enforced between issues, so the downstream banks see long enable-low stretches that the clock-gating flow can exploit.

## Interface
- WIDTH, 5, data width, matches downstream D_IN
- DEPTH, 4, FIFO entries, power of two, ≥2
- GAP, 1, idle cycles forced after every issue, 0–15
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- IN_VALID  in  1  upstream word valid
- IN_READY  out  1  block can accept a word
- IN_DATA  in  WIDTH  word payload
- IN_DEST  in  2  destination: 01 bank1, 10 bank2, 11 both, 00 invalid
- D_OUT  out  WIDTH  data to downstream D_IN
- EN1  out  1  one-cycle write strobe, bank1
- EN2  out  1  one-cycle write strobe, bank2
- BUSY  out  1  FIFO non-empty, or FSM not IDLE, or a strobe high
- DROP_CNT  out  8  count of words accepted with IN_DEST=00, saturating at 255

## Operation
- Transfer occurs on a rising edge with IN_VALID && IN_READY.
- IN_READY = !full, derived from the registered occupancy only; a same-cycle pop does not free a slot.
- IN_DEST=00 words are accepted but not stored; DROP_CNT increments, holds at 255.
- Other words are written as {IN_DEST, IN_DATA} into the FIFO tail.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load D_OUT, set EN1 = dest[0], EN2 = dest[1]; go to ISSUE. Otherwise stay, strobes low.
  - ISSUE: strobes drop to 0. If GAP=0, behave as IDLE in the same cycle (a pop is allowed, giving back-to-back issues). Else load gap counter with GAP-1 and go to HOLD.
  - HOLD: decrement the counter; at 0 go to IDLE. Strobes low, no pops.
- D_OUT holds the last issued value between issues and never toggles without a strobe.
- Issue order is strict FIFO; no reordering by bank.
- Reset: all outputs 0, FIFO empty, FSM IDLE, DROP_CNT 0, gap counter 0. Asserting reset mid-operation discards pending words; strobes drop asynchronously.

## Timing
- Latency, empty FIFO and FSM IDLE: word accepted at edge k → D_OUT/EN valid after edge k+1 → downstream captures at edge k+2.
- Each strobe is high for exactly one cycle per issued word.
- Issue spacing: one issue per GAP+1 cycles when GAP>0; one per cycle when GAP=0.
- FIFO full with IN_VALID high: IN_READY=0, and IN_DATA must be held by upstream.
- Simultaneous push and pop, non-full FIFO: both happen; occupancy unchanged.
- FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- First release edge after reset deasserts: IN_READY=1, no strobe.

## Structure
- Package enable_sched_pkg holds:
  - dest codes DEST_NONE/DEST_B1/DEST_B2/DEST_BOTH
  - FSM state typedef {IDLE, ISSUE, HOLD}
  - DROP_MAX=255
- Sub-module sync_fifo: width WIDTH+2, depth DEPTH. Ports: CLK, RST, push, pop, wdata, rdata, full, empty.
- Top module holds the FSM, gap counter, output registers, and DROP_CNT.

## Test plan
- After reset, push 5'h15 dest 01 at edge 1 → EN1=1, EN2=0, D_OUT=5'h15 in cycle after edge 2; EN1 low next cycle; BUSY low after GAP.
- GAP=1: push 5'h03/01, 5'h1C/10, 5'h0F/11 back-to-back → strobes issue every 2 cycles in order; last issue has EN1=EN2=1 with D_OUT=5'h0F.
- Hold IN_VALID with no pops possible → IN_READY drops after 4 accepts; 5th word waits and is accepted one cycle after the first pop frees a slot.
- Push 300 words with dest 00 → DROP_CNT=255; no strobes; FIFO stays empty.
- GAP=0, fill FIFO with 4 words → 4 consecutive single-cycle strobes; D_OUT changes each cycle.
- Assert RST mid-stream with 3 words queued → outputs 0 immediately; after release no strobe fires and BUSY=0.

Source files
------------

// File: rtl/enable_sched_pkg.sv
// rtl/enable_sched_pkg.sv - shared types and constants for the enable scheduler
package enable_sched_pkg;

    typedef enum logic [1:0] {
        DEST_NONE = 2'b00,
        DEST_B1   = 2'b01,
        DEST_B2   = 2'b10,
        DEST_BOTH = 2'b11
    } dest_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    localparam int DROP_MAX = 255;

endpackage

// File: rtl/enable_scheduler_if.sv
// rtl/enable_scheduler_if.sv - upstream handshake and downstream strobe bus
interface enable_scheduler_if #(
    parameter int WIDTH = 5
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic [1:0]       IN_DEST;
    logic [WIDTH-1:0] D_OUT;
    logic             EN1;
    logic             EN2;
    logic             BUSY;
    logic [7:0]       DROP_CNT;

    modport master (
        output IN_VALID, IN_DATA, IN_DEST,
        input  IN_READY, D_OUT, EN1, EN2, BUSY, DROP_CNT
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_DEST,
        output IN_READY, D_OUT, EN1, EN2, BUSY, DROP_CNT
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, extra pointer bit separates full from empty
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full) r_wptr <= r_wptr + (AW+1)'(1);
            if (pop && !empty) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/enable_scheduler.sv
// rtl/enable_scheduler.sv - buffers tagged words and issues them as gapped EN1/EN2 strobes
module enable_scheduler
    import enable_sched_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic               CLK,
    input  logic               RST,
    enable_scheduler_if.slave  bus
);
    localparam int FW = WIDTH + 2;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [FW-1:0] w_head;

    state_e           r_state;
    logic [3:0]       r_gap_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_en1;
    logic             r_en2;
    logic [7:0]       r_drop_cnt;

    assign bus.IN_READY = !w_full && !RST;
    assign w_accept     = bus.IN_VALID && bus.IN_READY;
    assign w_drop       = w_accept && (bus.IN_DEST == DEST_NONE);
    assign w_push       = w_accept && (bus.IN_DEST != DEST_NONE);
    // With no gap the strobe cycle doubles as an idle cycle, so back-to-back pops are legal.
    assign w_pop        = !w_empty && ((r_state == IDLE) || ((r_state == ISSUE) && (GAP == 0)));

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus.IN_DEST, bus.IN_DATA}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // The strobe cycle plus GAP low cycles spans GAP+1 edges; the last low cycle is IDLE so it can pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_dout    <= '0;
            r_en1     <= 1'b0;
            r_en2     <= 1'b0;
        end else begin
            r_en1 <= 1'b0;
            r_en2 <= 1'b0;
            if (w_pop) begin
                r_dout <= w_head[WIDTH-1:0];
                r_en1  <= w_head[WIDTH];
                r_en2  <= w_head[WIDTH+1];
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) r_state <= ISSUE;
                end
                ISSUE: begin
                    if (GAP == 0) begin
                        r_state <= w_pop ? ISSUE : IDLE;
                    end else if (GAP == 1) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= 4'(GAP - 1);
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                    if (r_gap_cnt <= 4'd1) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'(DROP_MAX))) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.D_OUT    = r_dout;
    assign bus.EN1      = r_en1;
    assign bus.EN2      = r_en2;
    assign bus.DROP_CNT = r_drop_cnt;
    assign bus.BUSY     = !w_empty || (r_state != IDLE) || r_en1 || r_en2;
endmodule

// File: tb/tb_enable_scheduler.sv
// tb/tb_enable_scheduler.sv - three schedulers (GAP 1, 0, 3) checked against a queue model
module tb_enable_scheduler;
    localparam int NG = 3;
    localparam int W  = 5;
    localparam int D  = 4;

    function automatic int gap_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic [1:0]   s_dest = 2'b00;

    always #5 clk = ~clk;

    logic         ready_a [NG];
    logic         en1_a   [NG];
    logic         en2_a   [NG];
    logic         busy_a  [NG];
    logic [W-1:0] dout_a  [NG];
    logic [7:0]   drop_a  [NG];

    genvar g;
    generate
        for (g = 0; g < NG; g++) begin : g_dut
            enable_scheduler_if #(.WIDTH(W)) bus ();
            assign bus.IN_VALID = s_valid;
            assign bus.IN_DATA  = s_data;
            assign bus.IN_DEST  = s_dest;
            assign ready_a[g]   = bus.IN_READY;
            assign en1_a[g]     = bus.EN1;
            assign en2_a[g]     = bus.EN2;
            assign busy_a[g]    = bus.BUSY;
            assign dout_a[g]    = bus.D_OUT;
            assign drop_a[g]    = bus.DROP_CNT;
            enable_scheduler #(.WIDTH(W), .DEPTH(D), .GAP(gap_of(g))) dut (
                .CLK (clk),
                .RST (rst),
                .bus (bus.slave)
            );
        end
    endgenerate

    logic [6:0]   mq [NG][$];
    int           m_wait [NG];
    int           m_drop [NG];
    logic [W-1:0] m_dout [NG];
    logic         m_en1  [NG];
    logic         m_en2  [NG];

    int         log_cyc [NG][$];
    logic [6:0] log_val [NG][$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int gi, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, gi, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NG; i++) begin
            mq[i].delete();
            m_wait[i] = 0;
            m_drop[i] = 0;
            m_dout[i] = '0;
            m_en1[i]  = 1'b0;
            m_en2[i]  = 1'b0;
        end
    endtask

    // One rising edge: issue from the pre-edge queue if the quiet window has expired, then accept.
    task automatic model_step();
        logic [6:0] h;
        bit rdy;
        for (int i = 0; i < NG; i++) begin
            rdy = (mq[i].size() < D);
            if (m_wait[i] == 0 && mq[i].size() > 0) begin
                h = mq[i].pop_front();
                m_dout[i] = h[4:0];
                m_en1[i]  = h[5];
                m_en2[i]  = h[6];
                m_wait[i] = gap_of(i);
            end else begin
                m_en1[i] = 1'b0;
                m_en2[i] = 1'b0;
                if (m_wait[i] > 0) m_wait[i]--;
            end
            if (s_valid && rdy) begin
                if (s_dest == 2'b00) begin
                    if (m_drop[i] < 255) m_drop[i]++;
                end else begin
                    mq[i].push_back({s_dest, s_data});
                end
            end
        end
    endtask

    task automatic compare_all();
        logic exp_ready;
        logic exp_busy;
        for (int i = 0; i < NG; i++) begin
            exp_ready = rst ? 1'b0 : (mq[i].size() < D);
            exp_busy  = rst ? 1'b0 : ((mq[i].size() > 0) || (m_wait[i] > 0) || m_en1[i] || m_en2[i]);
            chk("in_ready", i, ready_a[i], exp_ready);
            chk("d_out", i, dout_a[i], m_dout[i]);
            chk("en1", i, en1_a[i], m_en1[i]);
            chk("en2", i, en2_a[i], m_en2[i]);
            chk("busy", i, busy_a[i], exp_busy);
            chk("drop_cnt", i, drop_a[i], m_drop[i]);
            if (en1_a[i] || en2_a[i]) begin
                log_cyc[i].push_back(cyc);
                log_val[i].push_back({en2_a[i], en1_a[i], dout_a[i]});
            end
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NG; i++) begin
            log_cyc[i].delete();
            log_val[i].delete();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        model_reset();
        cycle();
        cycle();
        chk("reset_d_out", 0, dout_a[0], 5'h00);
        chk("reset_busy", 0, busy_a[0], 1'b0);
        chk("reset_drop", 0, drop_a[0], 8'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", 0, ready_a[0], 1'b1);

        // single word latency
        s_valid = 1'b1; s_data = 5'h15; s_dest = 2'b01;
        cycle();
        s_valid = 1'b0;
        cycle();
        chk("first_en1", 0, en1_a[0], 1'b1);
        chk("first_en2", 0, en2_a[0], 1'b0);
        chk("first_dout", 0, dout_a[0], 5'h15);
        cycle();
        chk("first_en1_drop", 0, en1_a[0], 1'b0);
        chk("first_dout_hold", 0, dout_a[0], 5'h15);
        chk("first_busy_low", 0, busy_a[0], 1'b0);
        repeat (6) cycle();

        // three-word ordering and spacing
        clear_logs();
        s_valid = 1'b1; s_data = 5'h03; s_dest = 2'b01; cycle();
        s_data = 5'h1C; s_dest = 2'b10; cycle();
        s_data = 5'h0F; s_dest = 2'b11; cycle();
        s_valid = 1'b0;
        repeat (16) cycle();
        chk("b_count", 0, log_cyc[0].size(), 3);
        if (log_cyc[0].size() == 3) begin
            chk("b_space01", 0, log_cyc[0][1] - log_cyc[0][0], 2);
            chk("b_space12", 0, log_cyc[0][2] - log_cyc[0][1], 2);
            chk("b_val0", 0, log_val[0][0], {2'b01, 5'h03});
            chk("b_val1", 0, log_val[0][1], {2'b10, 5'h1C});
            chk("b_val2", 0, log_val[0][2], {2'b11, 5'h0F});
        end
        chk("b_count", 2, log_cyc[2].size(), 3);
        if (log_cyc[2].size() == 3) chk("b_space01", 2, log_cyc[2][1] - log_cyc[2][0], 4);

        // continuous push: full / back-pressure on the GAP=3 instance
        s_valid = 1'b1; s_dest = 2'b01;
        for (int i = 0; i < 12; i++) begin
            s_data = 5'(i + 1);
            cycle();
            if (i == 4) chk("c_full", 2, ready_a[2], 1'b0);
            if (i == 5) chk("c_freed", 2, ready_a[2], 1'b1);
            if (i == 6) chk("c_refull", 2, ready_a[2], 1'b0);
        end
        s_valid = 1'b0;
        repeat (30) cycle();

        // dest 00 words are counted, never stored
        s_valid = 1'b1; s_dest = 2'b00;
        repeat (300) begin
            s_data = 5'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        for (int i = 0; i < NG; i++) begin
            chk("d_drop_sat", i, drop_a[i], 8'd255);
            chk("d_idle", i, busy_a[i], 1'b0);
        end

        // GAP=0 back-to-back issues
        clear_logs();
        s_valid = 1'b1; s_dest = 2'b10;
        s_data = 5'h01; cycle();
        s_data = 5'h02; cycle();
        s_data = 5'h04; cycle();
        s_data = 5'h08; cycle();
        s_valid = 1'b0;
        repeat (20) cycle();
        chk("e_count", 1, log_cyc[1].size(), 4);
        if (log_cyc[1].size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("e_space", 1, log_cyc[1][i] - log_cyc[1][i-1], 1);
                chk("e_dout_change", 1, (log_val[1][i] != log_val[1][i-1]), 1'b1);
            end
            chk("e_last", 1, log_val[1][3], {2'b10, 5'h08});
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 5'($urandom);
            s_dest  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cycle();
        end
        s_valid = 1'b0;
        repeat (30) cycle();

        // reset mid-stream
        s_valid = 1'b1; s_dest = 2'b11;
        s_data = 5'h0A; cycle();
        s_data = 5'h0B; cycle();
        s_data = 5'h0C; cycle();
        s_valid = 1'b0;
        chk("f_busy_before", 2, busy_a[2], 1'b1);
        chk("f_en_before", 1, en1_a[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NG; i++) begin
            chk("f_async_en1", i, en1_a[i], 1'b0);
            chk("f_async_en2", i, en2_a[i], 1'b0);
            chk("f_async_dout", i, dout_a[i], 5'h00);
            chk("f_async_busy", i, busy_a[i], 1'b0);
            chk("f_async_drop", i, drop_a[i], 8'd0);
        end
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        clear_logs();
        repeat (10) cycle();
        for (int i = 0; i < NG; i++) begin
            chk("f_no_strobe", i, log_cyc[i].size(), 0);
            chk("f_busy_after", i, busy_a[i], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
